jesd204b_tx_link_fsm: RTL and testbench

//  Tx link-layer control in the link-clock domain, downstream of the 1-bit event CDC.

---
 rtl/jesd204b_tx_link_fsm_pkg.sv | 23 ++
 rtl/jesd204b_tx_link_fsm_if.sv | 35 +++
 rtl/jesd204b_tx_link_fsm_lmfc.sv | 49 ++++
 rtl/jesd204b_tx_link_fsm.sv | 123 ++++++++++++
 tb/tb_jesd204b_tx_link_fsm.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/jesd204b_tx_link_fsm_pkg.sv
// Shared JESD204B Tx link-layer definitions: FSM state encoding, control
// characters and LMFC sizing helpers.
package jesd204b_pkg;

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_ILAS = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [7:0] K28_5   = 8'hBC;
  localparam logic [7:0] K28_0_R = 8'h1C;
  localparam logic [7:0] K28_3_A = 8'h7C;
  localparam logic [7:0] K28_4_Q = 8'h9C;

  // LMFC period in link-clock cycles (4 octets per clock)
  function automatic int lmfc_p(input int f, input int k);
    return (f * k) / 4;
  endfunction

  function automatic int lmfc_cw(input int f, input int k);
    return (lmfc_p(f, k) > 1) ? $clog2(lmfc_p(f, k)) : 1;
  endfunction

endpackage

// File: rtl/jesd204b_tx_link_fsm_if.sv
// Link-control bundle between the Tx link FSM and its environment:
// SYSREF event / SYNC~ inputs and the octet-mux / status outputs.
interface jesd204b_tx_link_fsm_if #(
  parameter int F = 2,
  parameter int K = 16
);
  import jesd204b_pkg::*;

  localparam int CW = lmfc_cw(F, K);

  logic          sysref_evt;
  logic          sync_n;
  logic          cgs_en;
  logic          ilas_en;
  logic          data_en;
  logic [1:0]    ilas_mf_idx;
  logic [CW-1:0] lmfc_cnt;
  logic          lmfc_edge;
  logic          aligned;
  logic          err_report;
  logic          phase_err;

  modport master (
    output sysref_evt, sync_n,
    input  cgs_en, ilas_en, data_en, ilas_mf_idx, lmfc_cnt, lmfc_edge,
           aligned, err_report, phase_err
  );

  modport slave (
    input  sysref_evt, sync_n,
    output cgs_en, ilas_en, data_en, ilas_mf_idx, lmfc_cnt, lmfc_edge,
           aligned, err_report, phase_err
  );

endinterface

// File: rtl/jesd204b_tx_link_fsm_lmfc.sv
// LMFC phase counter with SYSREF event acceptance (optional one-shot),
// alignment status and detection of realigns that move the phase.
module jesd204b_lmfc_counter #(
  parameter int P       = 8,
  parameter int CW      = 3,
  parameter int ONESHOT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sysref_evt,
  output logic [CW-1:0] cnt,
  output logic          lmfc_edge,
  output logic          aligned,
  output logic          wrap,
  output logic          realign_moved
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          edge_q, edge_d;
  logic          aligned_q, aligned_d;
  logic          accept;

  always_comb begin
    wrap          = (cnt_q == CW'(P - 1));
    accept        = sysref_evt && ((ONESHOT == 0) || !aligned_q);
    // a reload landing on the natural wrap leaves the phase untouched
    realign_moved = accept && !wrap;
    cnt_d         = (accept || wrap) ? '0 : cnt_q + CW'(1);
    edge_d        = (cnt_d == '0);
    aligned_d     = aligned_q | accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      edge_q    <= 1'b1;
      aligned_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      aligned_q <= aligned_d;
    end
  end

  assign cnt       = cnt_q;
  assign lmfc_edge = edge_q;
  assign aligned   = aligned_q;

endmodule

// File: rtl/jesd204b_tx_link_fsm.sv
// JESD204B Tx link-layer control: SYNC~-driven CGS -> ILAS -> DATA sequencing
// on the LMFC grid, with SYNC~ error/resync monitoring. All outputs registered.
module jesd204b_tx_link_fsm
  import jesd204b_pkg::*;
#(
  parameter int F              = 2,
  parameter int K              = 16,
  parameter int ILAS_MF        = 4,
  parameter int RESYNC_CYC     = 4,
  parameter int SYSREF_ONESHOT = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  jesd204b_tx_link_fsm_if.slave lnk
);

  localparam int P  = lmfc_p(F, K);
  localparam int CW = lmfc_cw(F, K);
  localparam int LW = $clog2(RESYNC_CYC + 1);

  logic [CW-1:0] lmfc_cnt;
  logic          lmfc_edge, aligned, wrap, moved;
  logic [1:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [LW-1:0] low_q, low_d;
  logic          cgs_q, cgs_d, ilas_q, ilas_d, data_q, data_d;
  logic          err_q, err_d, perr_q, perr_d;
  logic          resync;

  jesd204b_lmfc_counter #(
    .P       (P),
    .CW      (CW),
    .ONESHOT (SYSREF_ONESHOT)
  ) u_lmfc (
    .clk           (clk),
    .rst_n         (rst_n),
    .sysref_evt    (lnk.sysref_evt),
    .cnt           (lmfc_cnt),
    .lmfc_edge     (lmfc_edge),
    .aligned       (aligned),
    .wrap          (wrap),
    .realign_moved (moved)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    low_d   = '0;
    resync  = 1'b0;
    if (state_q != ST_CGS && !lnk.sync_n) begin
      low_d  = (low_q == LW'(RESYNC_CYC)) ? low_q : low_q + LW'(1);
      resync = (low_q >= LW'(RESYNC_CYC - 1));
    end
    err_d  = (state_q == ST_DATA) && lnk.sync_n &&
             (low_q != '0) && (low_q < LW'(RESYNC_CYC));
    perr_d = moved && (state_q != ST_CGS);

    case (state_q)
      ST_CGS: begin
        if (lnk.sync_n && aligned && wrap) begin
          state_d = ST_ILAS;
          idx_d   = '0;
        end
      end
      ST_ILAS: begin
        if (wrap) begin
          if (idx_q == 2'(ILAS_MF - 1)) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DATA: ;
      default: state_d = ST_CGS;
    endcase

    // phase loss or resync request overrides any normal progression
    if (state_q != ST_CGS && (moved || resync)) begin
      state_d = ST_CGS;
      idx_d   = '0;
      low_d   = '0;
    end

    cgs_d  = (state_d == ST_CGS);
    ilas_d = (state_d == ST_ILAS);
    data_d = (state_d == ST_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CGS;
      idx_q   <= '0;
      low_q   <= '0;
      cgs_q   <= 1'b1;
      ilas_q  <= 1'b0;
      data_q  <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      low_q   <= low_d;
      cgs_q   <= cgs_d;
      ilas_q  <= ilas_d;
      data_q  <= data_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

  assign lnk.cgs_en      = cgs_q;
  assign lnk.ilas_en     = ilas_q;
  assign lnk.data_en     = data_q;
  assign lnk.ilas_mf_idx = idx_q;
  assign lnk.lmfc_cnt    = lmfc_cnt;
  assign lnk.lmfc_edge   = lmfc_edge;
  assign lnk.aligned     = aligned;
  assign lnk.err_report  = err_q;
  assign lnk.phase_err   = perr_q;

endmodule

// File: tb/tb_jesd204b_tx_link_fsm.sv
// Bench for jesd204b_tx_link_fsm: one-shot and every-event SYSREF instances
// against a timeline-based model (phase anchor, ILAS start time, low-run length).
module tb_jesd204b_tx_link_fsm;
  import jesd204b_pkg::*;

  localparam int P   = 8;
  localparam int IMF = 4;
  localparam int RC  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sre, sn;
  always #5 clk = ~clk;

  jesd204b_tx_link_fsm_if #(.F(2), .K(16)) if0 ();
  jesd204b_tx_link_fsm_if #(.F(2), .K(16)) if1 ();
  assign if0.sysref_evt = sre;
  assign if0.sync_n     = sn;
  assign if1.sysref_evt = sre;
  assign if1.sync_n     = sn;

  jesd204b_tx_link_fsm #(.F(2), .K(16), .ILAS_MF(4), .RESYNC_CYC(4), .SYSREF_ONESHOT(1))
    dut0 (.clk(clk), .rst_n(rst_n), .lnk(if0));
  jesd204b_tx_link_fsm #(.F(2), .K(16), .ILAS_MF(4), .RESYNC_CYC(4), .SYSREF_ONESHOT(0))
    dut1 (.clk(clk), .rst_n(rst_n), .lnk(if1));

  int total = 0;
  int bad   = 0;
  int c     = 0;

  // mode: 0 CGS, 1 ILAS, 2 DATA; phase is (cycle - anchor) mod P
  typedef struct {
    int anchor;
    bit aligned;
    int mode;
    int ilas_start;
    int low_run;
    bit err;
    bit perr;
  } mdl_t;
  mdl_t m [2];

  function automatic mdl_t mreset(input int at);
    mdl_t r;
    r.anchor = at; r.aligned = 0; r.mode = 0; r.ilas_start = 0;
    r.low_run = 0; r.err = 0; r.perr = 0;
    return r;
  endfunction

  function automatic int mcnt(input mdl_t x, input int cy);
    return (cy - x.anchor) % P;
  endfunction

  function automatic int midx(input mdl_t x, input int cy);
    return (x.mode == 1) ? (cy - x.ilas_start) / P : 0;
  endfunction

  function automatic mdl_t mstep(input mdl_t x, input int cy, input bit e, input bit s,
                                 input bit oneshot);
    mdl_t r;
    int cur;
    bit acc, moved, resync;
    r      = x;
    cur    = mcnt(x, cy);
    acc    = e && (!oneshot || !x.aligned);
    moved  = acc && (cur != P - 1);
    resync = (x.mode != 0) && !s && (x.low_run + 1 >= RC);
    r.err  = (x.mode == 2) && s && (x.low_run >= 1) && (x.low_run <= RC - 1);
    r.perr = moved && (x.mode != 0);
    if (acc) r.anchor = cy + 1;
    r.aligned = x.aligned | acc;
    if (x.mode != 0 && (moved || resync)) r.mode = 0;
    else if (x.mode == 0 && s && x.aligned && cur == P - 1) begin
      r.mode = 1;
      r.ilas_start = cy + 1;
    end else if (x.mode == 1 && (cy + 1 - x.ilas_start) == IMF * P) r.mode = 2;
    if (x.mode == 0 || r.mode == 0 || s) r.low_run = 0;
    else r.low_run = (x.low_run < RC) ? x.low_run + 1 : RC;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic cmp_one(input int k, input logic cg, input logic il, input logic da,
                         input int cnt, input logic ed, input logic al, input int idx,
                         input logic er, input logic pe);
    chk($sformatf("d%0d.cgs_en", k),      int'(cg),  int'(m[k].mode == 0));
    chk($sformatf("d%0d.ilas_en", k),     int'(il),  int'(m[k].mode == 1));
    chk($sformatf("d%0d.data_en", k),     int'(da),  int'(m[k].mode == 2));
    chk($sformatf("d%0d.lmfc_cnt", k),    cnt,       mcnt(m[k], c));
    chk($sformatf("d%0d.lmfc_edge", k),   int'(ed),  int'(mcnt(m[k], c) == 0));
    chk($sformatf("d%0d.aligned", k),     int'(al),  int'(m[k].aligned));
    chk($sformatf("d%0d.ilas_mf_idx", k), idx,       midx(m[k], c));
    chk($sformatf("d%0d.err_report", k),  int'(er),  int'(m[k].err));
    chk($sformatf("d%0d.phase_err", k),   int'(pe),  int'(m[k].perr));
  endtask

  task automatic compare_all();
    cmp_one(0, if0.cgs_en, if0.ilas_en, if0.data_en, int'(if0.lmfc_cnt), if0.lmfc_edge,
            if0.aligned, int'(if0.ilas_mf_idx), if0.err_report, if0.phase_err);
    cmp_one(1, if1.cgs_en, if1.ilas_en, if1.data_en, int'(if1.lmfc_cnt), if1.lmfc_edge,
            if1.aligned, int'(if1.ilas_mf_idx), if1.err_report, if1.phase_err);
  endtask

  // drive inputs for the coming edge, advance the models, compare after the edge
  task automatic cyc(input bit e, input bit s);
    sre = e;
    sn  = s;
    for (int k = 0; k < 2; k++)
      m[k] = rst_n ? mstep(m[k], c, e, s, (k == 0)) : mreset(c + 1);
    @(negedge clk);
    c++;
    compare_all();
  endtask

  initial begin
    int n, pulses, dataok, lowrem;
    bit e, s;
    sre = 1'b0;
    sn  = 1'b1;
    m[0] = mreset(0);
    m[1] = mreset(0);
    @(negedge clk);
    compare_all();
    chk("rst.cgs_en", int'(if0.cgs_en), 1);
    chk("rst.lmfc_cnt", int'(if0.lmfc_cnt), 0);
    chk("rst.aligned", int'(if0.aligned), 0);
    repeat (3) cyc(0, 1);
    rst_n = 1'b1;

    repeat (20) cyc(0, 1);
    chk("noref.cgs_en", int'(if0.cgs_en), 1);
    chk("noref.aligned", int'(if1.aligned), 0);
    chk("noref.lmfc_cnt", int'(if0.lmfc_cnt), 4);

    while (mcnt(m[0], c) != 3) cyc(0, 1);
    cyc(1, 1);
    chk("align.lmfc_cnt", int'(if0.lmfc_cnt), 0);
    chk("align.aligned", int'(if0.aligned), 1);
    n = 1;
    while (!if0.data_en && n < 100) begin
      cyc(0, 1);
      n++;
    end
    chk("align.data_latency", n, 41);

    cyc(0, 0);
    cyc(0, 0);
    pulses = 0;
    dataok = 1;
    repeat (4) begin
      cyc(0, 1);
      pulses += int'(if0.err_report);
      if (!if0.data_en) dataok = 0;
    end
    chk("short.err_pulses", pulses, 1);
    chk("short.data_en", dataok, 1);

    repeat (4) cyc(0, 0);
    chk("resync.cgs_en", int'(if0.cgs_en), 1);
    chk("resync.data_en", int'(if0.data_en), 0);
    n = 0;
    while (!if0.ilas_en && n < 20) begin
      cyc(0, 1);
      n++;
    end
    chk("reilas.ilas_en", int'(if0.ilas_en), 1);
    chk("reilas.lmfc_cnt", int'(if0.lmfc_cnt), 0);

    while (mcnt(m[1], c) != 7) cyc(0, 1);
    cyc(1, 1);
    chk("wrapref.phase_err", int'(if1.phase_err), 0);
    chk("wrapref.ilas_en", int'(if1.ilas_en), 1);
    while (mcnt(m[1], c) != 5) cyc(0, 1);
    cyc(1, 1);
    chk("realign.phase_err", int'(if1.phase_err), 1);
    chk("realign.cgs_en", int'(if1.cgs_en), 1);
    chk("realign.lmfc_cnt", int'(if1.lmfc_cnt), 0);
    chk("oneshot.ilas_en", int'(if0.ilas_en), 1);
    chk("oneshot.lmfc_cnt", int'(if0.lmfc_cnt), 6);
    cyc(0, 1);
    chk("realign.pulse_end", int'(if1.phase_err), 0);

    repeat (3) cyc(0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.cgs_en", int'(if0.cgs_en), 1);
    chk("midrst.ilas_en", int'(if0.ilas_en), 0);
    chk("midrst.lmfc_cnt", int'(if0.lmfc_cnt), 0);
    chk("midrst.aligned", int'(if0.aligned), 0);
    chk("midrst.ilas_mf_idx", int'(if0.ilas_mf_idx), 0);
    @(negedge clk);
    c++;
    m[0] = mreset(c);
    m[1] = mreset(c);
    compare_all();
    repeat (2) cyc(0, 1);
    rst_n = 1'b1;
    while (mcnt(m[0], c) != 3) cyc(0, 1);
    cyc(1, 1);
    chk("reacc.aligned", int'(if0.aligned), 1);
    chk("reacc.lmfc_cnt", int'(if0.lmfc_cnt), 0);

    lowrem = 0;
    repeat (3000) begin
      e = ($urandom_range(0, 149) == 0);
      if (lowrem > 0) begin
        s = 1'b0;
        lowrem--;
      end else if ($urandom_range(0, 24) == 0) begin
        s = 1'b0;
        lowrem = $urandom_range(0, 5);
      end else begin
        s = 1'b1;
      end
      cyc(e, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
